// File: rtl/idct_block_arbiter.sv
// idct_block_arbiter: round-robin scheduler that shares one pipelined 8x8 IDCT
// core among N_CH row-serial stream producers. It gathers a full 8-row block
// from the granted channel, waits out the core latency, then captures the
// result and drains it as 8 tagged rows. Loading of the next block overlaps
// draining of the previous one.
module idct_block_arbiter #(
  parameter int unsigned WIN      = 16,
  parameter int unsigned WOUT     = 9,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CORE_LAT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_CH-1:0]           ch_enable,
  input  logic [N_CH*WIN*8-1:0]     s_tdata,
  input  logic [N_CH-1:0]           s_tvalid,
  output logic [N_CH-1:0]           s_tready,
  output logic [WIN*64-1:0]         core_in,
  input  logic [WOUT*64-1:0]        core_out,
  output logic [WOUT*8-1:0]         m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [$clog2(N_CH)-1:0]   m_tdest,
  output logic                      m_tlast,
  output logic                      busy
);

  localparam int unsigned IN_ROW_W  = WIN * 8;
  localparam int unsigned OUT_ROW_W = WOUT * 8;
  localparam int unsigned CH_W      = $clog2(N_CH);
  localparam int unsigned LAT_W     = $clog2(CORE_LAT + 1);

  typedef enum logic [1:0] {IN_ARB, IN_LOAD, IN_WAIT, IN_HOLD} in_state_e;
  typedef enum logic       {OUT_IDLE, OUT_DRAIN}                out_state_e;

  // Input side state
  in_state_e              in_state_q, in_state_d;
  logic [CH_W-1:0]        grant_q, grant_d;
  logic [CH_W-1:0]        last_q, last_d;
  logic [2:0]             in_cnt_q, in_cnt_d;
  logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
  logic [WIN*64-1:0]      core_in_q, core_in_d;
  logic [N_CH-1:0]        s_tready_q, s_tready_d;

  // Output side state
  out_state_e             out_state_q, out_state_d;
  logic [2:0]             out_cnt_q, out_cnt_d;
  logic [WOUT*64-1:0]     out_buff_q, out_buff_d;
  logic [CH_W-1:0]        dest_q, dest_d;
  logic [OUT_ROW_W-1:0]   m_tdata_q, m_tdata_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [CH_W-1:0]        m_tdest_q, m_tdest_d;
  logic                   m_tlast_q, m_tlast_d;
  logic                   busy_q, busy_d;

  // Combinational helpers
  logic [N_CH-1:0]        req_c;
  logic                   arb_found_c;
  logic [CH_W-1:0]        arb_pick_c;
  logic [CH_W-1:0]        arb_idx_c;
  logic [IN_ROW_W-1:0]    s_row_c;
  logic                   s_vld_sel_c;
  logic                   m_hs_c;
  logic                   out_free_c;
  logic                   capture_c;
  logic [OUT_ROW_W-1:0]   m_row_c;

  assign s_tready = s_tready_q;
  assign core_in  = core_in_q;
  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tdest  = m_tdest_q;
  assign m_tlast  = m_tlast_q;
  assign busy     = busy_q;

  // Handshake and hand-over conditions between the two FSMs
  assign m_hs_c     = (out_state_q == OUT_DRAIN) && m_tready;
  assign out_free_c = (out_state_q == OUT_IDLE) || (m_hs_c && (out_cnt_q == 3'd7));
  assign capture_c  = (in_state_q == IN_HOLD) && out_free_c;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    req_c       = s_tvalid & ch_enable;
    arb_found_c = 1'b0;
    arb_pick_c  = '0;
    arb_idx_c   = '0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      arb_idx_c = CH_W'((32'(last_q) + off) % N_CH);
      if (!arb_found_c && req_c[arb_idx_c]) begin
        arb_found_c = 1'b1;
        arb_pick_c  = arb_idx_c;
      end
    end
  end

  // Select the granted channel's row and valid
  always_comb begin
    s_row_c     = '0;
    s_vld_sel_c = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (grant_q == CH_W'(i)) begin
        s_row_c     = s_tdata[i*IN_ROW_W +: IN_ROW_W];
        s_vld_sel_c = s_tvalid[i];
      end
    end
  end

  // Input FSM: arbitrate, load 8 rows, wait core latency, hold for capture
  always_comb begin
    in_state_d = in_state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    in_cnt_d   = in_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    core_in_d  = core_in_q;
    case (in_state_q)
      IN_ARB: begin
        if (arb_found_c) begin
          grant_d    = arb_pick_c;
          last_d     = arb_pick_c;
          in_cnt_d   = '0;
          in_state_d = IN_LOAD;
        end
      end
      IN_LOAD: begin
        if (s_vld_sel_c) begin
          for (int r = 0; r < 8; r++) begin
            if (in_cnt_q == 3'(r)) begin
              core_in_d[r*IN_ROW_W +: IN_ROW_W] = s_row_c;
            end
          end
          in_cnt_d = in_cnt_q + 3'd1;
          if (in_cnt_q == 3'd7) begin
            lat_cnt_d  = '0;
            in_state_d = IN_WAIT;
          end
        end
      end
      IN_WAIT: begin
        if (lat_cnt_q == LAT_W'(CORE_LAT - 1)) begin
          lat_cnt_d  = '0;
          in_state_d = IN_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      IN_HOLD: begin
        if (out_free_c) begin
          in_state_d = IN_ARB;
        end
      end
      default: in_state_d = IN_ARB;
    endcase
    s_tready_d = (in_state_d == IN_LOAD) ? (N_CH'(1) << grant_d) : '0;
  end

  // Output FSM: capture a finished block and drain it row by row
  always_comb begin
    out_state_d = out_state_q;
    out_cnt_d   = out_cnt_q;
    out_buff_d  = out_buff_q;
    dest_d      = dest_q;
    case (out_state_q)
      OUT_IDLE: out_state_d = OUT_IDLE;
      OUT_DRAIN: begin
        if (m_hs_c) begin
          out_cnt_d = out_cnt_q + 3'd1;
          if (out_cnt_q == 3'd7) begin
            out_state_d = OUT_IDLE;
          end
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase
    // A capture on the row-7 edge keeps the stream gapless
    if (capture_c) begin
      out_buff_d  = core_out;
      dest_d      = grant_q;
      out_cnt_d   = '0;
      out_state_d = OUT_DRAIN;
    end
  end

  // Registered output beat, zeroed whenever no row is presented
  always_comb begin
    m_row_c = '0;
    for (int r = 0; r < 8; r++) begin
      if (out_cnt_d == 3'(r)) begin
        m_row_c = out_buff_d[r*OUT_ROW_W +: OUT_ROW_W];
      end
    end
    m_tvalid_d = (out_state_d == OUT_DRAIN);
    m_tdata_d  = m_tvalid_d ? m_row_c : '0;
    m_tdest_d  = m_tvalid_d ? dest_d : '0;
    m_tlast_d  = m_tvalid_d && (out_cnt_d == 3'd7);
    busy_d     = (in_state_d != IN_ARB) || (out_state_d == OUT_DRAIN);
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      in_state_q  <= IN_ARB;
      grant_q     <= '0;
      last_q      <= CH_W'(N_CH - 1);
      in_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      core_in_q   <= '0;
      s_tready_q  <= '0;
      out_state_q <= OUT_IDLE;
      out_cnt_q   <= '0;
      out_buff_q  <= '0;
      dest_q      <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdest_q   <= '0;
      m_tlast_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      in_cnt_q    <= in_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      core_in_q   <= core_in_d;
      s_tready_q  <= s_tready_d;
      out_state_q <= out_state_d;
      out_cnt_q   <= out_cnt_d;
      out_buff_q  <= out_buff_d;
      dest_q      <= dest_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdest_q   <= m_tdest_d;
      m_tlast_q   <= m_tlast_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_idct_block_arbiter.sv
// Directed bench for idct_block_arbiter: row producers, a delayed in+1 core
// model and an output collector feed checks made in one linear sequence.
module tb_idct_block_arbiter;

  localparam int WIN      = 16;
  localparam int WOUT     = 9;
  localparam int N_CH     = 4;
  localparam int CORE_LAT = 4;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [N_CH-1:0]        ch_enable = '1;
  logic [N_CH*WIN*8-1:0]  s_tdata = '0;
  logic [N_CH-1:0]        s_tvalid = '0;
  logic [N_CH-1:0]        s_tready;
  logic [WIN*64-1:0]      core_in;
  logic [WOUT*64-1:0]     core_out;
  logic [WOUT*8-1:0]      m_tdata;
  logic                   m_tvalid;
  logic                   m_tready = 1'b1;
  logic [1:0]             m_tdest;
  logic                   m_tlast;
  logic                   busy;

  idct_block_arbiter #(.WIN(WIN), .WOUT(WOUT), .N_CH(N_CH), .CORE_LAT(CORE_LAT)) dut (
    .clock(clock), .reset(reset), .ch_enable(ch_enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .core_in(core_in), .core_out(core_out),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdest(m_tdest), .m_tlast(m_tlast), .busy(busy)
  );

  always #5 clock = ~clock;

  // Core model: every coefficient +1, delivered CORE_LAT edges later
  logic [WOUT*64-1:0] core_f;
  logic [WOUT*64-1:0] pipe [CORE_LAT];
  always_comb begin
    core_f = '0;
    for (int i = 0; i < 64; i++) core_f[i*WOUT +: WOUT] = WOUT'(core_in[i*WIN +: WIN] + 16'd1);
  end
  always @(posedge clock) begin
    pipe[0] <= core_f;
    for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[CORE_LAT-1];

  typedef struct {
    logic [WOUT*8-1:0] data;
    logic [1:0]        dest;
    logic              last;
    int                cyc;
  } beat_t;

  int    tests = 0;
  int    fails = 0;
  int    rows_left [N_CH];
  int    row_idx   [N_CH];
  int    blk_idx   [N_CH];
  int    stall_cnt [N_CH];
  int    stall_at  [N_CH];
  int    stall_len = 0;
  int    cyc = 0;
  int    e0_edge = -1;
  int    first_tv_edge = -1;
  bit    ch2_rdy_seen = 1'b0;
  bit    hs_pend [N_CH];
  bit    m_hs_pend = 1'b0;
  beat_t pend_beat;
  beat_t outq[$];
  int    grant_log[$];

  function automatic logic [WIN*8-1:0] in_row(input int c, input int b, input int r);
    logic [WIN*8-1:0] v;
    for (int k = 0; k < 8; k++) v[k*WIN +: WIN] = WIN'(c*64 + r*8 + k + (b % 2)*256);
    return v;
  endfunction

  function automatic logic [WOUT*8-1:0] exp_row(input int c, input int b, input int r);
    logic [WOUT*8-1:0] v;
    for (int k = 0; k < 8; k++) v[k*WOUT +: WOUT] = WOUT'(c*64 + r*8 + k + (b % 2)*256 + 1);
    return v;
  endfunction

  // Producers and output collector: drive at negedge, latch handshakes mid-cycle
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      for (int c = 0; c < N_CH; c++) begin
        if (hs_pend[c]) begin
          if (row_idx[c] == 0) grant_log.push_back(c);
          if (stall_at[c] == row_idx[c]) begin
            stall_cnt[c] = stall_len;
            stall_at[c]  = -1;
          end
          rows_left[c]--;
          if (row_idx[c] == 7) begin
            row_idx[c] = 0;
            blk_idx[c]++;
            e0_edge = cyc;
          end else begin
            row_idx[c]++;
          end
        end
      end
      if (m_hs_pend) outq.push_back(pend_beat);
      for (int c = 0; c < N_CH; c++) begin
        if (stall_cnt[c] > 0) begin
          s_tvalid[c] = 1'b0;
          stall_cnt[c]--;
        end else begin
          s_tvalid[c] = (rows_left[c] > 0);
        end
        s_tdata[c*WIN*8 +: WIN*8] = in_row(c, blk_idx[c], row_idx[c]);
      end
      if (m_tvalid && first_tv_edge < 0) first_tv_edge = cyc;
      #2;
      for (int c = 0; c < N_CH; c++) hs_pend[c] = !reset && s_tvalid[c] && s_tready[c];
      if (!reset && s_tready[2]) ch2_rdy_seen = 1'b1;
      m_hs_pend = !reset && m_tvalid && m_tready;
      pend_beat = '{m_tdata, m_tdest, m_tlast, cyc + 1};
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_prod();
    for (int c = 0; c < N_CH; c++) begin
      rows_left[c] = 0;
      row_idx[c]   = 0;
      blk_idx[c]   = 0;
      stall_cnt[c] = 0;
      stall_at[c]  = -1;
    end
  endtask

  task automatic clear_phase();
    outq.delete();
    grant_log.delete();
    first_tv_edge = -1;
    e0_edge       = -1;
    ch2_rdy_seen  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_prod();
    step();
    step();
    reset = 1'b0;
    clear_phase();
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_s_tready"}, 128'(s_tready), 128'(0));
    chk({pfx, "_m_tvalid"}, 128'(m_tvalid), 128'(0));
    chk({pfx, "_m_tdata"},  128'(m_tdata),  128'(0));
    chk({pfx, "_m_tdest"},  128'(m_tdest),  128'(0));
    chk({pfx, "_m_tlast"},  128'(m_tlast),  128'(0));
    chk({pfx, "_busy"},     128'(busy),     128'(0));
    chk({pfx, "_core_in"},  128'(|core_in), 128'(0));
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    int k = 0;
    while (outq.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 128'(outq.size() >= n), 128'(1));
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int k = 0;
    while (grant_log.size() < 1 && k < budget) begin
      step();
      k++;
    end
    chk(tag, 128'(grant_log.size() >= 1), 128'(1));
  endtask

  task automatic check_block(input string tag, input int base, input int ch, input int b);
    beat_t e;
    for (int r = 0; r < 8; r++) begin
      if (base + r < outq.size()) begin
        e = outq[base + r];
        chk($sformatf("%s_r%0d_data", tag, r), 128'(e.data), 128'(exp_row(ch, b, r)));
        chk($sformatf("%s_r%0d_dest", tag, r), 128'(e.dest), 128'(ch));
        chk($sformatf("%s_r%0d_last", tag, r), 128'(e.last), 128'(r == 7));
        if (r > 0) chk($sformatf("%s_r%0d_gap", tag, r), 128'(e.cyc - outq[base + r - 1].cyc), 128'(1));
      end else begin
        chk($sformatf("%s_r%0d_present", tag, r), 128'(outq.size()), 128'(base + r + 1));
      end
    end
  endtask

  initial begin
    int k;
    int ord2 [8];
    int ord3 [4];
    ord2 = '{0, 1, 2, 3, 0, 1, 2, 3};
    ord3 = '{0, 1, 3, 0};
    clear_prod();
    step();
    chk_zero("reset");
    step();
    reset = 1'b0;
    clear_phase();

    // Single channel 0 block and first-row latency
    rows_left[0] = 8;
    wait_out("s1_rows", 8, 80);
    check_block("s1", 0, 0, 0);
    chk("s1_latency", 128'(first_tv_edge - e0_edge), 128'(CORE_LAT + 1));
    repeat (10) step();
    chk("s1_count", 128'(outq.size()), 128'(8));
    chk("s1_busy_end", 128'(busy), 128'(0));
    chk("s1_grant", 128'(grant_log[0]), 128'(0));

    // All channels valid: round-robin order and contiguous tagged blocks
    do_reset();
    for (int c = 0; c < N_CH; c++) rows_left[c] = 16;
    wait_out("s2_rows", 64, 400);
    chk("s2_ngrant", 128'(grant_log.size()), 128'(8));
    for (int i = 0; i < 5; i++) chk($sformatf("s2_grant%0d", i), 128'(grant_log[i]), 128'(ord2[i]));
    for (int b = 0; b < 8; b++) check_block($sformatf("s2_b%0d", b), b*8, ord2[b], b/4);

    // Channel 2 masked off
    do_reset();
    ch_enable = 4'b1011;
    rows_left[0] = 16;
    rows_left[1] = 8;
    rows_left[2] = 8;
    rows_left[3] = 8;
    wait_out("s3_rows", 32, 300);
    chk("s3_ngrant", 128'(grant_log.size()), 128'(4));
    for (int i = 0; i < 4; i++) chk($sformatf("s3_grant%0d", i), 128'(grant_log[i]), 128'(ord3[i]));
    chk("s3_ch2_ready", 128'(ch2_rdy_seen), 128'(0));
    chk("s3_ch2_rows", 128'(rows_left[2]), 128'(8));
    for (int b = 0; b < 4; b++) check_block($sformatf("s3_b%0d", b), b*8, ord3[b], b/3);
    do_reset();
    ch_enable = '1;

    // Downstream stall: second block parks in HOLD, then both drain gaplessly
    m_tready = 1'b0;
    rows_left[0] = 16;
    k = 0;
    while (first_tv_edge < 0 && k < 60) begin
      step();
      k++;
    end
    chk("s4_first_valid", 128'(first_tv_edge >= 0), 128'(1));
    repeat (20) step();
    chk("s4_busy", 128'(busy), 128'(1));
    chk("s4_no_out", 128'(outq.size()), 128'(0));
    chk("s4_loaded", 128'(rows_left[0]), 128'(0));
    chk("s4_tready", 128'(s_tready), 128'(0));
    chk("s4_tvalid", 128'(m_tvalid), 128'(1));
    m_tready = 1'b1;
    wait_out("s4_rows", 16, 60);
    check_block("s4_b0", 0, 0, 0);
    check_block("s4_b1", 8, 0, 1);
    if (outq.size() >= 9) chk("s4_bubble", 128'(outq[8].cyc - outq[7].cyc), 128'(1));
    repeat (5) step();
    chk("s4_busy_end", 128'(busy), 128'(0));

    // Channel 1 stalls 3 cycles after row 3: grant held, rows in order
    do_reset();
    rows_left[1] = 8;
    stall_at[1]  = 3;
    stall_len    = 3;
    k = 0;
    while (row_idx[1] != 4 && k < 40) begin
      step();
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s5_hold_ready%0d", i), 128'(s_tready), 128'(4'b0010));
      chk($sformatf("s5_stall_valid%0d", i), 128'(s_tvalid[1]), 128'(0));
      step();
    end
    wait_out("s5_rows", 8, 60);
    check_block("s5", 0, 1, 0);
    chk("s5_ngrant", 128'(grant_log.size()), 128'(1));
    chk("s5_grant", 128'(grant_log[0]), 128'(1));

    // Reset in LOAD at row 5
    do_reset();
    rows_left[0] = 16;
    k = 0;
    while (row_idx[0] != 5 && k < 40) begin
      step();
      k++;
    end
    chk("s6_reached_row5", 128'(row_idx[0]), 128'(5));
    reset = 1'b1;
    clear_prod();
    step();
    chk_zero("s6_load_rst");
    reset = 1'b0;
    clear_phase();
    rows_left[0] = 8;
    rows_left[1] = 8;
    wait_grant("s6_grant_seen", 20);
    chk("s6_grant_after_rst", 128'(grant_log[0]), 128'(0));

    // Reset in DRAIN at row 2
    wait_out("s6_two_rows", 2, 60);
    reset = 1'b1;
    clear_prod();
    step();
    chk_zero("s6_drain_rst");
    reset = 1'b0;
    clear_phase();
    repeat (40) step();
    chk("s6_residual", 128'(outq.size()), 128'(0));
    chk("s6_idle_busy", 128'(busy), 128'(0));
    chk("s6_idle_valid", 128'(m_tvalid), 128'(0));
    rows_left[0] = 8;
    rows_left[3] = 8;
    wait_grant("s6_grant2_seen", 20);
    chk("s6_grant2_after_rst", 128'(grant_log[0]), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
